regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised multi-read-port register file for the pipelined CPU, with one write port (write-back) and one reservation port (issue).
- Adds internal write-through bypass, so decode sees same-cycle write-back data without a half-cycle read clock.
- Adds a per-register busy scoreboard that flags operands with an in-flight producer.
- Register 0 optionally hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed combinational read data; port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  per-port operand-not-ready flag
- we  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- rsv_en  in  1  issue: mark rsv_addr busy
- rsv_addr  in  ADDR_W  destination being reserved
- flush  in  1  synchronous clear of all busy bits (pipeline flush)
- busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, busy_cnt = 0. rd_data then reads 0 at every port, and rd_busy = 0.
- Write: on the rising edge with we=1, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: combinational.
  - rd_data[k] = reg[rd_addr[k]].
  - If BYPASS=1, we=1 and wr_addr=rd_addr[k] (and the address is not a dropped zero write), rd_data[k] = wr_data.
  - If ZERO_REG=1 and rd_addr[k]=0, rd_data[k] = 0 regardless of any other condition.
- Busy bits, updated on the rising edge, in priority order:
  1. flush=1: all busy bits <= 0. A same-cycle rsv_en is ignored; a same-cycle write still updates data.
  2. Otherwise, rsv_en=1 sets busy[rsv_addr].
  3. we=1 clears busy[wr_addr].
  4. If rsv_addr = wr_addr with both enabled, set wins (the new producer supersedes).
  5. If ZERO_REG=1, busy[0] is never set.
- rd_busy[k] = busy[rd_addr[k]] AND NOT (BYPASS=1 and we=1 and wr_addr = rd_addr[k]).
  - A same-cycle write-back to the address makes the operand ready.
  - A same-cycle rsv_en does not affect rd_busy until the next cycle.
- busy_cnt: registered population count of the busy bits after each edge's update. Range 0..2**ADDR_W (0..31 when ZERO_REG=1).
- Reserving an already-busy register: the bit stays set and the count does not change.
- Writing a non-busy register: data updates, no busy change.
- Multiple read ports may address the same register and all receive identical data and busy values.
- rst asserted mid-cycle: state clears immediately. Deassertion takes effect on the next rising edge.
- Latency:
  - write to architectural read (no bypass): 1 edge
  - write to read with BYPASS=1: 0 cycles
  - reserve to rd_busy: 1 edge

Test Plan:
- Reset: preload reg6=50 via write, reserve r4, assert rst mid-cycle -> immediately rd_data for addr 6 = 0, rd_busy=0, busy_cnt=0.
- Bypass: we=1, wr_addr=2, wr_data=1, rd_addr0=2 in the same cycle -> rd_data0=1 before the edge and still 1 after the edge with we=0. With BYPASS=0, the pre-edge value is the old content (0).
- Zero register: write 0xDEADBEEF to r0 and rsv_en on r0 -> rd_data for r0 = 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard:
  - rsv r4 at cycle n -> rd_busy for r4 = 1 from n+1, busy_cnt=1.
  - Write r4=15 at cycle n+3 -> rd_busy=0 combinationally in n+3; busy_cnt=0 after the edge.
- Collision: rsv_en and we both on r6 (wr_data=50) -> after the edge reg6=50 and busy[6]=1.
- Flush: reserve r1, r2, r3 (busy_cnt=3), then flush together with rsv r5 -> busy_cnt=0 and r5 not busy. A NUM_RD=4 build reads all four ports consistently.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with write-through
// bypass and a per-register busy scoreboard for operand readiness.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_cnt;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_wr_zero;
  logic              w_we_eff;

  assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_we_eff  = we && !w_wr_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we_eff) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Reservation is applied after the write-back clear so a new
  // producer on the same register supersedes the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (we) begin
        w_busy_nxt[wr_addr] = 1'b0;
      end
      if (rsv_en) begin
        w_busy_nxt[rsv_addr] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_zero;
    logic              w_hit;

    assign w_a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_a == '0);
    assign w_hit  = (BYPASS != 0) && we && (wr_addr == w_a);

    assign rd_data[k*DATA_W +: DATA_W] =
      w_zero ? '0 : (w_hit ? wr_data : r_mem[w_a]);
    assign rd_busy[k] = r_busy[w_a] && !w_hit;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a 4-port bypassing instance and a
// 2-port non-bypassing instance share stimulus against a flat model.
module tb_regfile_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data_a;
  logic [NP-1:0]    rd_busy_a;
  logic [AW:0]      cnt_a;
  logic [2*DW-1:0]  rd_data_b;
  logic [1:0]       rd_busy_b;
  logic [AW:0]      cnt_b;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [32];
  bit            m_busy [32];

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy_cnt(cnt_a)
  );

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr[2*AW-1:0]), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy_cnt(cnt_b)
  );

  function automatic logic [AW-1:0] pa(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] da(input int k);
    return rd_data_a[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] db(input int k);
    return rd_data_b[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a,
                                             input bit byp);
    if (a == 0) return '0;
    if (byp && we && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    return m_busy[a] && !(byp && we && wr_addr == a);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_clear();
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
  endtask

  task automatic idle();
    we = 0; wr_addr = '0; wr_data = '0;
    rsv_en = 0; rsv_addr = '0; flush = 0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
    if (flush) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (we) m_busy[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rd_addr = '0; model_clear();
    @(negedge clk);
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (da(k) !== '0 || rd_busy_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_port%0d got d=%h b=%b want 0/0",
                 k, da(k), rd_busy_a[k]);
      end
    end
    checks++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0", cnt_a, cnt_b);
    end
    rst = 0;
    we = 1; wr_addr = 6; wr_data = 50;
    rsv_en = 1; rsv_addr = 4;
    tick();
    idle(); set_rd(0, 6); set_rd(1, 4);
    @(negedge clk);
    checks++;
    if (da(0) !== 32'd50 || rd_busy_a[1] !== 1'b1 || cnt_a !== 6'd1) begin
      errors++;
      $display("FAIL preload got d=%h b=%b c=%0d want 50/1/1",
               da(0), rd_busy_a[1], cnt_a);
    end
    #2 rst = 1;
    model_clear();
    #1;
    checks++;
    if (da(0) !== '0 || db(0) !== '0 || rd_busy_a !== '0 ||
        cnt_a !== '0 || cnt_b !== '0) begin
      errors++;
      $display("FAIL midreset got d=%h/%h b=%b c=%0d/%0d want 0",
               da(0), db(0), rd_busy_a, cnt_a, cnt_b);
    end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_bypass();
    idle(); rd_addr = '0;
    we = 1; wr_addr = 2; wr_data = 1; set_rd(0, 2);
    @(negedge clk);
    checks++;
    if (da(0) !== 32'd1) begin
      errors++;
      $display("FAIL bypass_pre got %h want 1", da(0));
    end
    checks++;
    if (db(0) !== 32'd0) begin
      errors++;
      $display("FAIL nobypass_pre got %h want 0", db(0));
    end
    tick();
    we = 0;
    @(negedge clk);
    checks++;
    if (da(0) !== 32'd1 || db(0) !== 32'd1) begin
      errors++;
      $display("FAIL bypass_post got %h/%h want 1", da(0), db(0));
    end
    tick();
  endtask

  task automatic test_zero();
    int prev;
    idle(); rd_addr = '0;
    prev = exp_cnt();
    we = 1; wr_addr = 0; wr_data = 32'hDEADBEEF;
    rsv_en = 1; rsv_addr = 0;
    @(negedge clk);
    checks++;
    if (da(0) !== '0 || rd_busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_pre got d=%h b=%b want 0/0", da(0), rd_busy_a[0]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (da(0) !== '0 || db(0) !== '0 || rd_busy_a[0] !== 1'b0 ||
        int'(cnt_a) !== prev) begin
      errors++;
      $display("FAIL zero_post got d=%h/%h b=%b c=%0d want 0/0/0/%0d",
               da(0), db(0), rd_busy_a[0], cnt_a, prev);
    end
  endtask

  task automatic test_scoreboard();
    idle(); rd_addr = '0;
    rsv_en = 1; rsv_addr = 4;
    tick();
    idle(); set_rd(0, 4);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1 ||
          cnt_a !== 6'd1) begin
        errors++;
        $display("FAIL sb_n+%0d got b=%b/%b c=%0d want 1/1/1",
                 c, rd_busy_a[0], rd_busy_b[0], cnt_a);
      end
      tick();
    end
    we = 1; wr_addr = 4; wr_data = 15;
    @(negedge clk);
    checks++;
    if (rd_busy_a[0] !== 1'b0 || da(0) !== 32'd15) begin
      errors++;
      $display("FAIL sb_wb got b=%b d=%h want 0/f", rd_busy_a[0], da(0));
    end
    checks++;
    if (rd_busy_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_nobyp got b=%b want 1", rd_busy_b[0]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (cnt_a !== 6'd0 || db(0) !== 32'd15 || rd_busy_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_post got c=%0d d=%h b=%b want 0/f/0",
               cnt_a, db(0), rd_busy_b[0]);
    end
  endtask

  task automatic test_collision();
    idle(); rd_addr = '0;
    we = 1; wr_addr = 6; wr_data = 50;
    rsv_en = 1; rsv_addr = 6;
    tick();
    idle(); set_rd(0, 6); set_rd(1, 6);
    @(negedge clk);
    checks++;
    if (da(0) !== 32'd50 || rd_busy_a[1:0] !== 2'b11 ||
        int'(cnt_a) !== exp_cnt()) begin
      errors++;
      $display("FAIL collision got d=%h b=%b c=%0d want 32/11/%0d",
               da(0), rd_busy_a[1:0], cnt_a, exp_cnt());
    end
  endtask

  task automatic test_flush();
    idle(); rd_addr = '0;
    we = 1; wr_addr = 6; wr_data = 50;
    tick();
    for (int r = 1; r <= 3; r++) begin
      idle(); rsv_en = 1; rsv_addr = AW'(r);
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (cnt_a !== 6'd3 || cnt_b !== 6'd3) begin
      errors++;
      $display("FAIL flush_pre got %0d/%0d want 3", cnt_a, cnt_b);
    end
    flush = 1; rsv_en = 1; rsv_addr = 5;
    tick();
    idle();
    set_rd(0, 5); set_rd(1, 1); set_rd(2, 2); set_rd(3, 3);
    @(negedge clk);
    checks++;
    if (cnt_a !== 6'd0 || rd_busy_a !== 4'b0000) begin
      errors++;
      $display("FAIL flush_post got c=%0d b=%b want 0/0000",
               cnt_a, rd_busy_a);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      idle();
      we       = ($urandom_range(0, 2) != 0);
      wr_addr  = AW'($urandom_range(0, 31));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 1) != 0);
      rsv_addr = AW'($urandom_range(0, 31));
      flush    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rsv_addr = wr_addr;
      a = AW'($urandom_range(0, 31));
      for (int k = 0; k < NP; k++) begin
        case ($urandom_range(0, 3))
          0: set_rd(k, wr_addr);
          1: set_rd(k, a);
          default: set_rd(k, AW'($urandom_range(0, 31)));
        endcase
      end
      @(negedge clk);
      for (int k = 0; k < NP; k++) begin
        checks++;
        if (da(k) !== exp_data(pa(k), 1'b1) ||
            rd_busy_a[k] !== exp_busy(pa(k), 1'b1)) begin
          errors++;
          $display("FAIL rnd%0d_a%0d got d=%h b=%b want d=%h b=%b",
                   n, k, da(k), rd_busy_a[k],
                   exp_data(pa(k), 1'b1), exp_busy(pa(k), 1'b1));
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (db(k) !== exp_data(pa(k), 1'b0) ||
            rd_busy_b[k] !== exp_busy(pa(k), 1'b0)) begin
          errors++;
          $display("FAIL rnd%0d_b%0d got d=%h b=%b want d=%h b=%b",
                   n, k, db(k), rd_busy_b[k],
                   exp_data(pa(k), 1'b0), exp_busy(pa(k), 1'b0));
        end
      end
      checks++;
      if (int'(cnt_a) !== exp_cnt() || int'(cnt_b) !== exp_cnt()) begin
        errors++;
        $display("FAIL rnd%0d_cnt got %0d/%0d want %0d",
                 n, cnt_a, cnt_b, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_collision();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
